// File: rtl/paula_uart_pkg.sv
// Shared constants and state types for the Paula-compatible UART with FIFOs.
package paula_uart_pkg;

  // Custom register word addresses (byte address >> 1)
  localparam logic [7:0] REG_SERDATR = 8'h0C;
  localparam logic [7:0] REG_SERDAT  = 8'h18;
  localparam logic [7:0] REG_SERPER  = 8'h19;

  // SERDATR status bit positions
  localparam int BIT_OVRUN = 15;
  localparam int BIT_RBF   = 14;
  localparam int BIT_TBE   = 13;
  localparam int BIT_TSRE  = 12;
  localparam int BIT_RXD   = 11;

  localparam int LONG_BIT = 15;

  typedef enum logic {
    TX_IDLE,
    TX_SHIFT
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_SHIFT
  } rx_state_t;

endpackage

// File: rtl/paula_sync_fifo.sv
// Single-clock FIFO with enable-qualified push/pop; a push into a full FIFO
// is accepted only when a pop frees a slot on the same tick.
module paula_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_FULL);
  assign empty   = (level == '0);
  assign do_pop  = en && pop && !empty;
  assign do_push = en && push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      level <= level + LVL_ONE;
      else if (do_pop && !do_push) level <= level - LVL_ONE;
    end
  end

endmodule

// File: rtl/paula_uart_fifo.sv
// Paula serial port (SERDAT/SERPER/SERDATR) with TX/RX FIFOs, level outputs
// and sticky frame-error capture.
//
// TX state  | meaning
// TX_IDLE   | line idle, waiting for a queued word
// TX_SHIFT  | start bit or data/stop bits on the line
//
// RX state  | meaning
// RX_IDLE   | waiting for a falling edge on rxds
// RX_START  | half-period wait to confirm the start bit
// RX_SHIFT  | sampling data bits, then the stop bit
module paula_uart_fifo
  import paula_uart_pkg::*;
#(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4,
  parameter int PER_W    = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clk7_en,
  input  logic [7:0]                  rga_i,
  input  logic [15:0]                 data_i,
  output logic [15:0]                 data_o,
  input  logic                        uartbrk,
  input  logic                        rbfmirror,
  output logic                        txint,
  output logic                        rxint,
  output logic                        txd,
  input  logic                        rxd,
  output logic [$clog2(TX_DEPTH):0]   tx_level,
  output logic [$clog2(RX_DEPTH):0]   rx_level,
  output logic                        frame_err
);

  localparam logic [PER_W:0] CNT_ONE = (PER_W+1)'(1);

  logic [15:0]    serper;
  logic [PER_W:0] reload;
  logic [PER_W:0] half;
  logic           long_mode;

  assign reload    = {serper[PER_W-1:0], 1'b1};
  assign half      = {1'b0, serper[PER_W-1:0]};
  assign long_mode = serper[LONG_BIT];

  // ---------------- TX ----------------
  tx_state_t      tx_state, tx_state_nx;
  logic [PER_W:0] tx_cnt;
  logic [15:0]    tx_sh;
  logic           txd_r;
  logic           tx_start, tx_bit, tx_done;
  logic           tx_full, tx_empty;
  logic [15:0]    tx_rdata;

  paula_sync_fifo #(.WIDTH(16), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (reset),
    .en    (clk7_en),
    .push  (rga_i == REG_SERDAT),
    .pop   (tx_start),
    .wdata (data_i),
    .rdata (tx_rdata),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

  always_comb begin
    tx_state_nx = tx_state;
    tx_start    = 1'b0;
    tx_bit      = 1'b0;
    tx_done     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_start    = 1'b1;
          tx_state_nx = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        if (tx_cnt == '0) begin
          if (tx_sh != '0) begin
            tx_bit = 1'b1;
          end else begin
            tx_done     = 1'b1;
            tx_state_nx = TX_IDLE;
          end
        end
      end
      default: tx_state_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_sh    <= '0;
      txd_r    <= 1'b1;
      txint    <= 1'b0;
    end else if (clk7_en) begin
      tx_state <= tx_state_nx;
      txint    <= tx_start;
      if (tx_start) begin
        tx_sh  <= tx_rdata;
        txd_r  <= 1'b0;
        tx_cnt <= reload;
      end else if (tx_bit) begin
        txd_r  <= tx_sh[0];
        tx_sh  <= {1'b0, tx_sh[15:1]};
        tx_cnt <= reload;
      end else if (tx_done) begin
        txd_r <= 1'b1;
      end else if (tx_cnt != '0) begin
        tx_cnt <= tx_cnt - CNT_ONE;
      end
    end
  end

  assign txd = uartbrk ? 1'b0 : txd_r;

  // ---------------- RX ----------------
  rx_state_t      rx_state, rx_state_nx;
  logic [1:0]     rxd_sync;
  logic           rxds;
  logic           rxds_prev;
  logic [PER_W:0] rx_cnt;
  logic [3:0]     rx_bits;
  logic [3:0]     rx_nd;
  logic [8:0]     rx_sh;
  logic [9:0]     rx_word;
  logic           rx_arm, rx_go, rx_sample, rx_frame;
  logic           rx_full, rx_empty, rx_deliver;
  logic [9:0]     rx_rdata;

  assign rxds  = rxd_sync[1];
  assign rx_nd = long_mode ? 4'd9 : 4'd8;
  // Stop bit always lands in bit 9; 8-bit data leaves bit 8 clear.
  assign rx_word = {rxds, rx_sh};

  always_comb begin
    rx_state_nx = rx_state;
    rx_arm      = 1'b0;
    rx_go       = 1'b0;
    rx_sample   = 1'b0;
    rx_frame    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rxds_prev && !rxds) begin
          rx_arm      = 1'b1;
          rx_state_nx = RX_START;
        end
      end
      RX_START: begin
        if (!rxds_prev && rxds) begin
          rx_state_nx = RX_IDLE;
        end else if (rx_cnt == '0) begin
          if (!rxds) begin
            rx_go       = 1'b1;
            rx_state_nx = RX_SHIFT;
          end else begin
            rx_state_nx = RX_IDLE;
          end
        end
      end
      RX_SHIFT: begin
        if (rx_cnt == '0) begin
          if (rx_bits == rx_nd) begin
            rx_frame    = 1'b1;
            rx_state_nx = RX_IDLE;
          end else begin
            rx_sample = 1'b1;
          end
        end
      end
      default: rx_state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_sync  <= 2'b11;
      rxds_prev <= 1'b1;
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_bits   <= '0;
      rx_sh     <= '0;
    end else if (clk7_en) begin
      rxd_sync  <= {rxd_sync[0], rxd};
      rxds_prev <= rxds;
      rx_state  <= rx_state_nx;
      if (rx_arm) begin
        rx_cnt <= half;
      end else if (rx_go) begin
        rx_cnt  <= reload;
        rx_bits <= '0;
        rx_sh   <= '0;
      end else if (rx_sample) begin
        rx_sh[rx_bits] <= rxds;
        rx_bits        <= rx_bits + 4'd1;
        rx_cnt         <= reload;
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - CNT_ONE;
      end
    end
  end

  paula_sync_fifo #(.WIDTH(10), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (reset),
    .en    (clk7_en),
    .push  (rx_frame),
    .pop   (rx_deliver),
    .wdata (rx_word),
    .rdata (rx_rdata),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level)
  );

  // ---------------- registers, delivery, status ----------------
  logic       rbf_r;
  logic       rx_pend;
  logic       ovrun;
  logic [9:0] rx_data;

  assign rx_deliver = !rx_pend && !rbfmirror && !rx_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      serper    <= '0;
      rbf_r     <= 1'b0;
      rx_pend   <= 1'b0;
      rx_data   <= '0;
      rxint     <= 1'b0;
      ovrun     <= 1'b0;
      frame_err <= 1'b0;
    end else if (clk7_en) begin
      rbf_r <= rbfmirror;
      rxint <= rx_deliver;
      if (rga_i == REG_SERPER) serper <= data_i;
      // One pop per RBF acknowledge: pend holds until RBF is seen set.
      if (rx_deliver) begin
        rx_data <= rx_rdata;
        rx_pend <= 1'b1;
      end else if (rbfmirror) begin
        rx_pend <= 1'b0;
      end
      if (rx_frame && rx_full && !rx_deliver) ovrun <= 1'b1;
      else if (rbf_r && !rbfmirror)           ovrun <= 1'b0;
      if (rx_frame && !rxds)                  frame_err <= 1'b1;
      else if (rga_i == REG_SERDATR)          frame_err <= 1'b0;
    end
  end

  logic [15:0] serdatr;

  always_comb begin
    serdatr            = '0;
    serdatr[BIT_OVRUN] = ovrun;
    serdatr[BIT_RBF]   = rbf_r;
    serdatr[BIT_TBE]   = !tx_full;
    serdatr[BIT_TSRE]  = tx_empty && (tx_state == TX_IDLE);
    serdatr[BIT_RXD]   = rxds_prev;
    serdatr[9:0]       = rx_data;
    data_o             = (rga_i == REG_SERDATR) ? serdatr : 16'h0000;
  end

endmodule

// File: doc/paula_uart_fifo.md
Name: paula_uart_fifo

Overview:
- Parametrised successor to the Paula serial port, with the same SERDAT/SERPER/SERDATR register map and custom-register bus.
- Adds configurable-depth TX and RX FIFOs, so the CPU can queue writes and the receiver can absorb bursts while RBF is pending.
- Adds FIFO level outputs and frame-error capture.
- Sits inside Paula, beside the interrupt controller, which supplies rbfmirror.

Parameters:
- TX_DEPTH, 4: TX FIFO entries; power of two, 2..16.
- RX_DEPTH, 4: RX FIFO entries; power of two, 2..16.
- PER_W, 15: SERPER period field width (bits [PER_W-1:0]); bit 15 is always LONG.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- clk7_en  in  1  7 MHz clock enable; all state advances only when high
- rga_i  in  8  custom register address (word address = byte address >> 1)
- data_i  in  16  register write data
- data_o  out  16  SERDATR read data; 0 when not addressed
- uartbrk  in  1  force txd low (ADKCON UARTBRK)
- rbfmirror  in  1  current INTREQ RBF bit
- txint  out  1  TBE interrupt pulse
- rxint  out  1  RBF interrupt pulse
- txd  out  1  serial out, idle high
- rxd  in  1  serial in, asynchronous
- tx_level  out  $clog2(TX_DEPTH)+1  TX FIFO occupancy
- rx_level  out  $clog2(RX_DEPTH)+1  RX FIFO occupancy
- frame_err  out  1  sticky: a stop bit was sampled low; cleared by any SERDATR read

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - txd=1, txint=0, rxint=0, frame_err=0, ovrun=0, both FIFOs empty.
  - SERPER=0, rx_data=0, both state machines idle.
- Tick: every rule below applies on clk edges where clk7_en=1.
- Bit period: 2*(SERPER[PER_W-1:0]+1) ticks. The counter reloads {SERPER[PER_W-1:0],1} and decrements to 0.
- rxd input: 2-flop synchroniser, reset to 11; the output is rxds.
- SERPER write (rga_i==0x32>>1): loads the register; takes effect at the next counter reload.
- SERDAT write (rga_i==0x30>>1): pushes data_i into the TX FIFO. If the FIFO is full, the write is dropped and the FIFO is unchanged.
- TX state machine, states TX_IDLE and TX_SHIFT:
  - TX_IDLE, FIFO non-empty: pop into the 16-bit shifter, drive txd=0 (start bit), load the counter, pulse txint for 1 tick, go to TX_SHIFT.
  - TX_SHIFT, counter==0 and shifter!=0: txd=shifter[0], shift right, reload the counter.
  - TX_SHIFT, counter==0 and shifter==0: go to TX_IDLE. Back-to-back words therefore have no idle gap beyond one tick.
  - uartbrk=1 overrides txd to 0 in any state; the state machine keeps running.
- TBE = TX FIFO not full.
- TSRE = TX FIFO empty AND TX_IDLE.
- RX state machine, states RX_IDLE, RX_START and RX_SHIFT:
  - RX_IDLE: a falling edge (previous rxds=1, rxds=0) loads the counter with SERPER[PER_W-1:0] (half period) and goes to RX_START.
  - RX_START, counter==0: rxds=0 goes to RX_SHIFT with a full reload; rxds=1 returns to RX_IDLE.
  - RX_START: a rising edge before the sample point returns to RX_IDLE.
  - RX_SHIFT: sample rxds at each counter==0. Data bits are 8 when LONG=0 and 9 when LONG=1, followed by 1 stop bit, LSB first.
  - Frame complete: the 10-bit word is {stop, data}, zero-extended to 10 bits. If the stop bit is low, set frame_err. Push the word into the RX FIFO if not full; otherwise drop it and set ovrun. Go to RX_IDLE.
- Delivery:
  - Condition: rx_pend=0, rbfmirror=0 and RX FIFO non-empty.
  - Action: pop into rx_data, pulse rxint for 1 tick, set rx_pend.
  - rx_pend clears when rbfmirror is sampled high. This guarantees one pop per RBF acknowledge.
  - If the FIFO is non-empty when RBF is cleared, the next pop occurs 1 tick after rbfmirror falls.
- ovrun is sticky; it clears on a registered falling edge of rbfmirror.
- Simultaneous events:
  - Push and pop on the same tick: both occur and the level is unchanged. This applies to both FIFOs.
  - Full FIFO plus pop plus push on the same tick: the push is accepted.
- SERDATR read (rga_i==0x18>>1): data_o = {ovrun, rbf_r, TBE, TSRE, rxd_r, 0, rx_data[9:0]}, where rbf_r and rxd_r are the registered rbfmirror and rxds.
- data_o is combinational from registers.

Decomposition:
- Package paula_uart_pkg:
  - Register address constants REG_SERDAT, REG_SERDATR, REG_SERPER.
  - SERDATR bit positions: OVRUN, RBF, TBE, TSRE, RXD.
  - LONG_BIT.
  - TX and RX state enums.
- Sub-module paula_sync_fifo (WIDTH, DEPTH): single clock, clk7_en-qualified push/pop, full, empty, level, async reset. Instantiated twice: TX at WIDTH=16, RX at WIDTH=10.

Test Plan:
1. SERPER=3 (8-tick bit), SERDAT=0x0155 → start bit, then bits 1,0,1,0,1,0,1,0,1 at 8-tick spacing, then txd=1. txint pulses once at the start bit. TSRE=1 after the final bit.
2. TX_DEPTH=4: write 6 words with no gap → the first 5 are accepted (1 goes to the shifter, 4 are queued) and the 6th is dropped. TBE=0 while full. The 5 frames go out back-to-back and txint pulses 5 times.
3. LONG=0, rxd sends 0xA5 with stop=1 → after the stop sample, rx_level=1. With rbfmirror=0, rx_data=0x2A5 and rxint pulses once. SERDATR[9:0]=0x2A5.
4. Hold rbfmirror=1 and send RX_DEPTH+1 frames → rx_level=RX_DEPTH and ovrun=1. Drop rbfmirror → ovrun=0 and the next word pops with an rxint pulse.
5. Send a frame with a low stop bit → frame_err=1. The SERDATR read clears it.
6. Assert reset mid-TX and mid-RX → txd=1 and levels=0 immediately, with no clk7_en needed. After release, a glitch on rxd shorter than half a bit returns RX to RX_IDLE with no push.
